// File: rtl/bsg_two_fifo_reader_width_p3_pkg.sv
// Shared constants for the two-entry ready/valid FIFO.
package bsg_two_fifo_reader_width_p3_pkg;

    // Default payload width in bits.
    localparam int WIDTH_DEFAULT = 3;

    // Entry count; the pointer/full-flag scheme only works for two entries.
    localparam int ELS_DEFAULT = 2;

endpackage

// File: rtl/bsg_two_fifo_reader_width_p3_dff.sv
// Width-parameterized register with load enable and async active-low clear.
module bsg_dff_en_async_reset_n
    import bsg_two_fifo_reader_width_p3_pkg::*;
#(
    parameter int width_p = WIDTH_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    // Load on enable; clear immediately when reset asserts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bsg_two_fifo_reader_width_p3.sv
// Two-entry FIFO with ready/valid input and valid/yumi output. Outputs come
// straight from registers, so there is no combinational path from the
// producer to the consumer side.
module bsg_two_fifo_reader_width_p3
    import bsg_two_fifo_reader_width_p3_pkg::*;
#(
    parameter int width_p = WIDTH_DEFAULT,
    parameter int els_p   = ELS_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic                          wptr;
    logic                          rptr;
    logic                          full;
    logic                          empty;
    logic                          enq;
    logic                          deq;
    logic [els_p-1:0][width_p-1:0] mem;

    // Equal pointers mean either empty or full; the full flag disambiguates.
    assign empty   = (wptr == rptr) && !full;
    assign ready_o = !full;
    assign v_o     = !empty;
    assign enq     = v_i && ready_o;
    assign deq     = yumi_i && v_o;
    assign data_o  = mem[rptr];

    // One storage register per entry; only the entry at wptr loads on enqueue.
    for (genvar i = 0; i < els_p; i++) begin : g_entry
        bsg_dff_en_async_reset_n #(
            .width_p (width_p)
        ) u_entry (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .en_i      (enq && (wptr == 1'(i))),
            .data_i    (data_i),
            .data_o    (mem[i])
        );
    end

    // Pointer and full-flag update; 1-bit pointers wrap naturally.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            full <= 1'b0;
        end else begin
            if (enq) wptr <= !wptr;
            if (deq) rptr <= !rptr;
            // Any dequeue frees a slot; an unmatched enqueue that catches the
            // read pointer fills the block.
            if (deq) begin
                full <= 1'b0;
            end else if (enq && ((!wptr) == rptr)) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bsg_two_fifo_reader_width_p3.sv
// Scoreboard bench: the stimulus pushes accepted payloads into a queue and
// tracks expected occupancy; a negedge monitor checks flags and pops on yumi.
module tb_bsg_two_fifo_reader_width_p3;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       v_i;
    logic [2:0] data_i;
    logic       ready_o;
    logic       v_o;
    logic [2:0] data_o;
    logic       yumi_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cnt      = 0;
    logic [2:0] exp_q[$];

    bsg_two_fifo_reader_width_p3 #(.width_p(3), .els_p(2)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i)
    );

    always #5 clk_i = !clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; the model decides acceptance from its own count.
    task automatic drive(input logic v, input logic [2:0] d, input logic y);
        bit e, q;
        v_i    = v;
        data_i = d;
        yumi_i = y;
        e = v && (cnt < 2);
        q = y && (cnt > 0);
        if (e) exp_q.push_back(d);
        @(posedge clk_i);
        cnt = cnt + int'(e) - int'(q);
        #1;
    endtask

    // Monitor: flags against model occupancy, payload against the queue.
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            check("ready_o", int'(ready_o), int'(cnt < 2));
            check("v_o", int'(v_o), int'(cnt > 0));
            if (v_o && yumi_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("data_o", int'(data_o), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        data_i    = 3'b000;
        yumi_i    = 1'b0;
        #12;
        check("reset_ready_o", int'(ready_o), 1);
        check("reset_v_o", int'(v_o), 0);
        check("reset_data_o", int'(data_o), 0);
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;

        // First enqueue after reset, one-cycle latency, then consume.
        drive(1'b1, 3'b101, 1'b0);
        check("first_data_o", int'(data_o), 5);
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);

        // Fill, dropped enqueue while full, drain in order.
        drive(1'b1, 3'b001, 1'b0);
        drive(1'b1, 3'b010, 1'b0);
        check("full_ready_o", int'(ready_o), 0);
        drive(1'b1, 3'b111, 1'b0);
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);

        // Streaming with one entry held: occupancy stays at one.
        drive(1'b1, 3'd0, 1'b0);
        for (int i = 1; i < 8; i++) drive(1'b1, 3'(i), 1'b1);
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);

        // Spurious yumi on an empty block, then a normal transfer.
        for (int i = 0; i < 3; i++) drive(1'b0, 3'b000, 1'b1);
        drive(1'b1, 3'b110, 1'b0);
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);

        // Mid-operation reset while full, observed before the next edge.
        drive(1'b1, 3'b011, 1'b0);
        drive(1'b1, 3'b100, 1'b0);
        v_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check("midrst_ready_o", int'(ready_o), 1);
        check("midrst_v_o", int'(v_o), 0);
        check("midrst_data_o", int'(data_o), 0);
        exp_q.delete();
        cnt = 0;
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4 && cnt > 0; i++) drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
